// File: rtl/addsub_div_seq_if.sv
// ============================================================================
// Module      : addsub_div_seq_if
// Description : Request/result handshake and add/sub-unit bus of the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addsub_div_seq_if #(
    parameter int W = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_err;
    logic [W-1:0] au_a;
    logic [W-1:0] au_b;
    logic         au_c0;
    logic         au_e;
    logic [W-1:0] au_result;
    logic         au_c;

    // Divider side
    modport slave (
        input  req_valid, dividend, divisor, res_ready, au_result, au_c,
        output req_ready, res_valid, quotient, remainder, div_err,
               au_a, au_b, au_c0, au_e
    );

    // Requester / consumer / add-sub unit side
    modport master (
        output req_valid, dividend, divisor, res_ready, au_result, au_c,
        input  req_ready, res_valid, quotient, remainder, div_err,
               au_a, au_b, au_c0, au_e
    );
endinterface

`default_nettype wire

// File: rtl/addsub_div_seq.sv
// ============================================================================
// Module      : addsub_div_seq
// Description : 8-bit unsigned restoring divider driving an external add/sub
//               unit for 8 iterations. Optional macro ADDSUB_DIV_STATS_EN adds
//               saturating op_count / err_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_div_seq #(
    parameter int W = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    addsub_div_seq_if.slave      bus
`ifdef ADDSUB_DIV_STATS_EN
    ,
    output logic [15:0]          op_count,
    output logic [7:0]           err_count
`endif
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [W-1:0]  r_d;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_r;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic          r_err;

    logic          w_accept;
    logic          w_zero;
    logic          w_req_ready;
    logic          w_res_valid;
    logic [W-1:0]  w_au_a;
    logic [W-1:0]  w_au_b;
    logic          w_au_c0;
    logic          w_au_e;

    logic [W-1:0]  w_t;
    logic          w_ovf;
    logic          w_take;
    logic [W-1:0]  w_r_next;
    logic [W-1:0]  w_n_next;

    // Restoring step: subtract succeeds when the shifted-out MSB overflowed
    // the partial remainder or the add/sub unit reports no borrow.
    assign w_zero   = (bus.divisor == '0);
    assign w_t      = {r_r[W-2:0], r_n[W-1]};
    assign w_ovf    = r_r[W-1];
    assign w_take   = w_ovf | bus.au_c;
    assign w_r_next = w_take ? bus.au_result : w_t;
    assign w_n_next = {r_n[W-2:0], w_take};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_req_ready = 1'b0;
        w_res_valid = 1'b0;
        w_au_a      = '0;
        w_au_b      = '0;
        w_au_e      = 1'b1;
        w_au_c0     = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? DONE : STEP;
                end
            end
            STEP: begin
                w_au_a  = w_t;
                w_au_b  = r_d;
                w_au_e  = 1'b0;
                w_au_c0 = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d    <= '0;
            r_n    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_zero) begin
                            r_quot <= '1;
                            r_rem  <= bus.dividend;
                            r_err  <= 1'b1;
                        end else begin
                            r_d   <= bus.divisor;
                            r_n   <= bus.dividend;
                            r_r   <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                STEP: begin
                    r_r   <= w_r_next;
                    r_n   <= w_n_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_quot <= w_n_next;
                        r_rem  <= w_r_next;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDSUB_DIV_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            err_count <= '0;
        end else begin
            if (w_accept && (op_count != '1)) begin
                op_count <= op_count + 1'b1;
            end
            if (w_accept && w_zero && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_err   = r_err;
    assign bus.au_a      = w_au_a;
    assign bus.au_b      = w_au_b;
    assign bus.au_c0     = w_au_c0;
    assign bus.au_e      = w_au_e;

endmodule

`default_nettype wire

// File: tb/tb_addsub_div_seq.sv
// ============================================================================
// Module      : tb_addsub_div_seq
// Description : Scoreboard bench for addsub_div_seq with a behavioural add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_div_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_div_seq_if bus ();

`ifdef ADDSUB_DIV_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  err_count;
`endif

    addsub_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ADDSUB_DIV_STATS_EN
        ,
        .op_count  (op_count),
        .err_count (err_count)
`endif
    );

    // Shared add/sub unit: E=1 -> A+B+C0, E=0 -> A+~B+C0
    logic [8:0] au_sum;
    always_comb begin
        au_sum = '0;
        if (bus.au_e)
            au_sum = {1'b0, bus.au_a} + {1'b0, bus.au_b} + {8'd0, bus.au_c0};
        else
            au_sum = {1'b0, bus.au_a} + {1'b0, ~bus.au_b} + {8'd0, bus.au_c0};
    end
    assign bus.au_result = au_sum[7:0];
    assign bus.au_c      = au_sum[8];

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total    = 0;

    task automatic send_req(input logic [7:0] a, input logic [7:0] b, output int waited);
        exp_t x;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        waited = 0;
        while (!bus.req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (b == 8'd0) x = '{q: 8'hFF, r: a, e: 1'b1};
        else           x = '{q: 8'(a / b), r: 8'(a % b), e: 1'b0};
        sb.push_back(x);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.dividend  = 8'($urandom);
        bus.divisor   = 8'($urandom);
    endtask

    task automatic wait_valid(output int lat, output int sub_cycles);
        lat = 0;
        sub_cycles = 0;
        @(negedge clk);
        while (!bus.res_valid && lat < 40) begin
            if (bus.au_e === 1'b0 && bus.au_c0 === 1'b1) sub_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    function automatic exp_t pop_exp();
        exp_t x;
        x = '0;
        if (sb.size() > 0) x = sb.pop_front();
        return x;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); else pass_cnt++;
        total++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); else pass_cnt++;
        total++; if (bus.quotient !== 8'd0) $display("FAIL reset_quotient: got %0d expected 0", bus.quotient); else pass_cnt++;
        total++; if (bus.remainder !== 8'd0) $display("FAIL reset_remainder: got %0d expected 0", bus.remainder); else pass_cnt++;
        total++; if (bus.div_err !== 1'b0) $display("FAIL reset_div_err: got %b expected 0", bus.div_err); else pass_cnt++;
        total++; if (bus.au_e !== 1'b1 || bus.au_a !== 8'd0) $display("FAIL reset_au: got e=%b a=%0d expected e=1 a=0", bus.au_e, bus.au_a); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int w, lat, sub;
        exp_t x;
        send_req(8'd200, 8'd7, w);
        total++; if (w !== 0) $display("FAIL normal_accept_wait: got %0d expected 0", w); else pass_cnt++;
        wait_valid(lat, sub);
        x = pop_exp();
        total++; if (lat !== 8) $display("FAIL normal_latency: got %0d expected 8", lat); else pass_cnt++;
        total++; if (sub !== 8) $display("FAIL normal_au_sub_cycles: got %0d expected 8", sub); else pass_cnt++;
        total++; if ({bus.quotient, bus.remainder, bus.div_err} !== x)
            $display("FAIL normal_result: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b",
                     bus.quotient, bus.remainder, bus.div_err, x.q, x.r, x.e);
        else pass_cnt++;
        total++; if (bus.req_ready !== 1'b0) $display("FAIL normal_done_req_ready: got %b expected 0", bus.req_ready); else pass_cnt++;
        ack();
    endtask

    task automatic test_edges();
        logic [7:0] as [10];
        logic [7:0] bs [10];
        int w, lat, sub;
        exp_t x;
        as[0] = 8'd200; bs[0] = 8'd129;
        as[1] = 8'd255; bs[1] = 8'd255;
        as[2] = 8'd255; bs[2] = 8'd1;
        as[3] = 8'd0;   bs[3] = 8'd5;
        as[4] = 8'd1;   bs[4] = 8'd255;
        for (int i = 5; i < 10; i++) begin
            as[i] = 8'($urandom);
            bs[i] = 8'($urandom_range(1, 255));
        end
        for (int i = 0; i < 10; i++) begin
            send_req(as[i], bs[i], w);
            wait_valid(lat, sub);
            x = pop_exp();
            total++; if (lat !== 8) $display("FAIL edge_latency %0d/%0d: got %0d expected 8", as[i], bs[i], lat); else pass_cnt++;
            total++; if ({bus.quotient, bus.remainder, bus.div_err} !== x)
                $display("FAIL edge_result %0d/%0d: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b",
                         as[i], bs[i], bus.quotient, bus.remainder, bus.div_err, x.q, x.r, x.e);
            else pass_cnt++;
            ack();
        end
    endtask

    task automatic test_div_zero();
        int w, lat, sub;
        exp_t x;
        send_req(8'd10, 8'd0, w);
        wait_valid(lat, sub);
        x = pop_exp();
        total++; if (lat !== 0) $display("FAIL divzero_latency: got %0d expected 0", lat); else pass_cnt++;
        total++; if ({bus.quotient, bus.remainder, bus.div_err} !== x)
            $display("FAIL divzero_result: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b",
                     bus.quotient, bus.remainder, bus.div_err, x.q, x.r, x.e);
        else pass_cnt++;
        ack();
        send_req(8'd9, 8'd3, w);
        wait_valid(lat, sub);
        x = pop_exp();
        total++; if ({bus.quotient, bus.remainder, bus.div_err} !== x)
            $display("FAIL after_divzero_result: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b",
                     bus.quotient, bus.remainder, bus.div_err, x.q, x.r, x.e);
        else pass_cnt++;
        ack();
    endtask

    task automatic test_back_to_back();
        int w, lat, sub;
        exp_t x;
        send_req(8'd77, 8'd5, w);
        wait_valid(lat, sub);
        x = pop_exp();
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({bus.quotient, bus.remainder, bus.div_err} !== x || bus.res_valid !== 1'b1 || bus.req_ready !== 1'b0)
                $display("FAIL hold_cycle_%0d: got q=%0d r=%0d e=%b v=%b rdy=%b expected q=%0d r=%0d e=%b v=1 rdy=0",
                         c, bus.quotient, bus.remainder, bus.div_err, bus.res_valid, bus.req_ready, x.q, x.r, x.e);
            else pass_cnt++;
            @(negedge clk);
        end
        ack();
        send_req(8'd100, 8'd9, w);
        total++; if (w !== 0) $display("FAIL b2b_accept_wait: got %0d expected 0", w); else pass_cnt++;
        wait_valid(lat, sub);
        x = pop_exp();
        total++; if ({bus.quotient, bus.remainder, bus.div_err} !== x)
            $display("FAIL b2b_result: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b",
                     bus.quotient, bus.remainder, bus.div_err, x.q, x.r, x.e);
        else pass_cnt++;
        ack();
    endtask

    task automatic test_reset_mid_op();
        int w, lat, sub, seen;
        exp_t x;
        send_req(8'd150, 8'd10, w);
        x = sb.pop_back();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.quotient !== 8'd0 || bus.remainder !== 8'd0)
            $display("FAIL midop_reset_state: got rdy=%b v=%b q=%0d r=%0d expected rdy=1 v=0 q=0 r=0",
                     bus.req_ready, bus.res_valid, bus.quotient, bus.remainder);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL midop_no_result: got %0d valid cycles expected 0", seen); else pass_cnt++;
        send_req(8'd150, 8'd10, w);
        wait_valid(lat, sub);
        x = pop_exp();
        total++; if (lat !== 8) $display("FAIL midop_rerun_latency: got %0d expected 8", lat); else pass_cnt++;
        total++; if ({bus.quotient, bus.remainder, bus.div_err} !== x)
            $display("FAIL midop_rerun_result: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=%b",
                     bus.quotient, bus.remainder, bus.div_err, x.q, x.r, x.e);
        else pass_cnt++;
        ack();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.dividend  = 8'd0;
        bus.divisor   = 8'd0;
        test_reset();
        test_normal();
        test_edges();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
